// File: rtl/watch_pkg.sv
// Shared constants, state encoding and time layout for the watch UART formatter.
// Holds the frame length, ASCII constants, FSM states and the BCD time struct.
package watch_pkg;

    localparam int         FRAME_LEN = 13;
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Each field holds two BCD digits, tens digit in the upper nibble.
    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic [7:0] cc;
    } bcd_time_t;

endpackage

// File: rtl/watch_bcd_ascii.sv
// Purpose: one BCD digit to its ASCII character, '?' for codes above 9.
// Latency: combinational. Backpressure: none, pure function.
module watch_bcd_ascii
    import watch_pkg::*;
(
    input  logic [3:0] bcd_dat,
    output logic [7:0] ascii_dat
);

    assign ascii_dat = (bcd_dat > 4'd9) ? ASCII_QMARK : (ASCII_ZERO | {4'h0, bcd_dat});

endmodule

// File: rtl/watch_uart_formatter.sv
// Purpose: serialise a BCD time snapshot as "HH:MM:SS.cc\r\n"; WATCH_UART_AUTO_SEND_EN adds a periodic start.
// Latency: first byte 1 cycle after the start event, 14 cycles to the last byte at full rate.
// Backpressure: byte and valid held while iTxReady is low; one start event is queued during a frame.
module watch_uart_formatter
    import watch_pkg::*;
#(
    parameter int P_AUTO_PERIOD_MS = 1000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iTick1kHz,
    input  logic [31:0] iFullData,
    input  logic        iSendReq,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    output logic        oBusy,
    output logic        oFrameDone
);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    bcd_time_t  snap_q, snap_d;
    logic       pend_q, pend_d;
    logic       done_q, done_d;

    logic       start_evt;
    logic       xfer;
    logic [3:0] nib_sel;
    logic [7:0] digit_ascii;
    logic [7:0] byte_mux;

`ifdef WATCH_UART_AUTO_SEND_EN
    localparam logic [15:0] AUTO_LAST = 16'(P_AUTO_PERIOD_MS - 1);

    logic [15:0] auto_cnt_q, auto_cnt_d;
    logic        auto_evt;

    always_comb begin
        auto_cnt_d = auto_cnt_q;
        auto_evt   = 1'b0;
        if (iTick1kHz) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_cnt_d = '0;
                auto_evt   = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign start_evt = iSendReq | auto_evt;
`else
    logic unused_auto_cfg;
    assign unused_auto_cfg = iTick1kHz | (P_AUTO_PERIOD_MS == 0);
    assign start_evt       = iSendReq;
`endif

    assign oTxValid   = (state_q == ST_SEND);
    assign oBusy      = oTxValid;
    assign oFrameDone = done_q;
    assign xfer       = oTxValid & iTxReady;

    // Byte index to digit position; separator slots leave the nibble unused.
    always_comb begin
        nib_sel = 4'h0;
        case (idx_q)
            4'd0:    nib_sel = snap_q.hh[7:4];
            4'd1:    nib_sel = snap_q.hh[3:0];
            4'd3:    nib_sel = snap_q.mm[7:4];
            4'd4:    nib_sel = snap_q.mm[3:0];
            4'd6:    nib_sel = snap_q.ss[7:4];
            4'd7:    nib_sel = snap_q.ss[3:0];
            4'd9:    nib_sel = snap_q.cc[7:4];
            4'd10:   nib_sel = snap_q.cc[3:0];
            default: nib_sel = 4'h0;
        endcase
    end

    watch_bcd_ascii u_bcd_ascii (
        .bcd_dat   (nib_sel),
        .ascii_dat (digit_ascii)
    );

    always_comb begin
        byte_mux = digit_ascii;
        case (idx_q)
            4'd2, 4'd5: byte_mux = ASCII_COLON;
            4'd8:       byte_mux = ASCII_DOT;
            4'd11:      byte_mux = ASCII_CR;
            4'd12:      byte_mux = ASCII_LF;
            default:    byte_mux = digit_ascii;
        endcase
    end

    assign oTxData = oTxValid ? byte_mux : 8'h00;

    // A queued start leaves exactly one IDLE cycle so the done pulse stays separate.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_evt || pend_q) begin
                    snap_d  = iFullData;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (start_evt) begin
                    pend_d = 1'b1;
                end
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/watch_uart_formatter.md
WATCH_UART_FORMATTER -- requirements
Module: watch_uart_formatter

Interface
REQ-001 SHALL have parameter P_AUTO_PERIOD_MS, default 1000, meaning the auto-send interval in 1 ms ticks (range 1..65535).
REQ-002 SHALL have port iClk, input, 1, the single system clock.
REQ-003 SHALL have port iRst, input, 1, reset, synchronous to iClk, active-high.
REQ-004 SHALL have port iTick1kHz, input, 1, 1 ms single-cycle tick.
REQ-005 SHALL have port iFullData, input, 32, time in BCD as {HH, MM, SS, cc}, 8 nibbles, MSB first.
REQ-006 SHALL have port iSendReq, input, 1, single-cycle request to transmit one frame.
REQ-007 SHALL have port oTxData, output, 8, ASCII byte offered to the UART transmitter.
REQ-008 SHALL have port oTxValid, output, 1, oTxData is valid.
REQ-009 SHALL have port iTxReady, input, 1, transmitter accepts oTxData this cycle.
REQ-010 SHALL have port oBusy, output, 1, frame in progress.
REQ-011 SHALL have port oFrameDone, output, 1, single-cycle pulse after the last byte is accepted.

Function
REQ-012 SHALL emit the 13-byte frame "HH:MM:SS.cc" followed by CR (0x0D) and LF (0x0A).
REQ-013 SHALL encode each BCD digit 0..9 as 0x30+digit and each digit >9 as '?' (0x3F).
REQ-014 SHALL use the FSM states IDLE and SEND only.
REQ-015 SHALL, in IDLE on a start event, snapshot iFullData into a 32-bit register, set byte index 0, and enter SEND on the next edge.
REQ-016 SHALL, when in SEND, assert oTxValid and drive oTxData from the snapshot and the index; the first byte appears 1 cycle after the start event.
REQ-017 SHALL count a byte as transferred only in a cycle with oTxValid and iTxReady both high; the index then increments.
REQ-018 SHALL hold oTxData and oTxValid stable while oTxValid=1 and iTxReady=0; oTxValid never drops before the transfer.
REQ-019 SHALL, on transfer of index 12, return to IDLE, deassert oTxValid the next cycle, and pulse oFrameDone for exactly 1 cycle.
REQ-020 SHALL drive oBusy high exactly while in SEND.
REQ-021 SHALL latch a start event arriving while in SEND into a 1-deep pending flag; additional events are dropped.
REQ-022 SHALL, if the pending flag is set on frame completion, start a new frame immediately with a fresh snapshot (IDLE for 1 cycle, no oFrameDone merge).
REQ-023 SHALL exclude live iFullData changes during a frame; only the snapshot is emitted.
REQ-024 SHALL support back-to-back transfers at iTxReady held high, 1 byte per cycle, giving a 14-cycle frame from start event to last transfer.

Reset
REQ-025 SHALL, on iRst=1, force IDLE, index 0, snapshot 0, pending 0, auto counter 0, oTxValid 0, oTxData 0x00, oBusy 0, and oFrameDone 0.
REQ-026 SHALL, when iRst is asserted mid-frame, abort the frame with no oFrameDone; the partial frame is not resumed.

Configuration
REQ-027 SHALL implement macro WATCH_UART_AUTO_SEND_EN such that, when defined, a 16-bit counter of iTick1kHz generates a start event every P_AUTO_PERIOD_MS ticks, OR-ed with iSendReq.
REQ-028 SHALL, when WATCH_UART_AUTO_SEND_EN is undefined, have no auto counter; only iSendReq starts frames, and P_AUTO_PERIOD_MS and iTick1kHz are unused.

Structure
REQ-029 SHALL place the frame length (13), ASCII constants (':', '.', CR, LF, '?', '0'), and FSM state encodings in the shared package watch_pkg.
REQ-030 SHALL use one sub-module, watch_bcd_ascii (4-bit BCD in, 8-bit ASCII out, '?' for >9); the byte mux and FSM stay inline.

Verification
REQ-031 SHALL verify: iFullData=32'h12345678, iSendReq pulse, iTxReady=1 -> bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A on 13 consecutive cycles, oFrameDone once.
REQ-032 SHALL verify: iTxReady toggled 1-of-3 cycles -> oTxData/oTxValid stable during stalls, same 13-byte sequence, no byte repeated or skipped.
REQ-033 SHALL verify: iFullData changed to 32'h23595999 after byte 2 -> remaining bytes still from 32'h12345678; a second iSendReq mid-frame yields exactly one follow-on frame with value 23:59:59.99.
REQ-034 SHALL verify: iFullData=32'hA0000000 -> first byte 0x3F.
REQ-035 SHALL verify: iRst pulsed after byte 5 -> oTxValid=0 next cycle, no oFrameDone, and the next iSendReq starts again at byte '0'-offset index 0.
REQ-036 SHALL verify, with WATCH_UART_AUTO_SEND_EN and P_AUTO_PERIOD_MS=3: frames start every 3 iTick1kHz ticks; without the macro, no frames occur without iSendReq.
